// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   One operation at a time. A start seen in IDLE captures the operands, the
//   op code and the destination index. CALC then runs WIDTH shift-add or
//   restoring-divide steps on operand magnitudes. DONE applies the sign and
//   the special cases. The registered outputs present the result one edge
//   later, so done rises 33 edges after the start edge.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, funct3         launch request and RV32M op select (sampled in IDLE)
//   rs1_val, rs2_val      operands A and B
//   rd_in                 destination register index
//   busy                  operation in flight, including the done cycle
//   done                  one-cycle result-valid pulse
//   result, rd_out        writeback data and index, held until the next done
//   rd_en                 writeback enable (done with a non-zero rd_out)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             rd_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [2:0]       r_op;
  logic [4:0]       r_rd;
  logic             r_neg_q;   // product / quotient must be negated
  logic             r_neg_r;   // remainder must be negated
  logic             r_divz;    // divisor was zero
  logic [WIDTH-1:0] r_a;       // raw A, returned as remainder on divide by zero
  logic [WIDTH-1:0] r_ma;      // |A|, multiplicand
  logic [WIDTH-1:0] r_mb;      // |B|, divisor
  logic [WIDTH-1:0] r_hi;      // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;      // multiplier bits / dividend bits then quotient
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_rd_out;

  logic             w_accept;
  logic             w_is_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_mul_step;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_final;

  // The done cycle itself is IDLE-state, so a start there must be blocked.
  assign w_accept = (r_state == S_IDLE) && start && !r_done;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_CALC;
        else          w_state_nxt = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == LAST_ITER) w_state_nxt = S_DONE;
        else                    w_state_nxt = S_CALC;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand sign decode and magnitudes for the capture edge.
  always_comb begin
    w_is_div = funct3[2];
    w_a_neg  = 1'b0;
    w_b_neg  = 1'b0;
    if (w_is_div) begin
      w_a_neg = ~funct3[0] & rs1_val[WIDTH-1];
      w_b_neg = ~funct3[0] & rs2_val[WIDTH-1];
    end else begin
      w_a_neg = ((funct3 == 3'b001) || (funct3 == 3'b010)) & rs1_val[WIDTH-1];
      w_b_neg = (funct3 == 3'b001) & rs2_val[WIDTH-1];
    end
    w_ma = w_a_neg ? -rs1_val : rs1_val;
    w_mb = w_b_neg ? -rs2_val : rs2_val;
  end

  // One shift-add or restoring-divide step.
  always_comb begin
    w_mul_sum  = {1'b0, r_hi} + {1'b0, r_ma};
    w_mul_step = r_lo[0] ? w_mul_sum : {1'b0, r_hi};
    w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_mb});
    if (r_op[2]) begin
      // When the subtract succeeds the difference is below |B|, so the low
      // WIDTH bits of the modular subtraction are exact.
      w_hi_nxt = w_ge ? (w_rem_sh[WIDTH-1:0] - r_mb) : w_rem_sh[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_nxt = w_mul_step[WIDTH:1];
      w_lo_nxt = {w_mul_step[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up, special cases and op select for the writeback value.
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_divz ? {WIDTH{1'b1}} : (r_neg_q ? -r_lo : r_lo);
    w_rem    = r_divz ? r_a : (r_neg_r ? -r_hi : r_hi);
    case (r_op)
      3'b000:                    w_final = w_prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011:    w_final = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:            w_final = w_quo;
      3'b110, 3'b111:            w_final = w_rem;
      default:                   w_final = {WIDTH{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 6'd0;
      r_op    <= 3'd0;
      r_rd    <= 5'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_divz  <= 1'b0;
      r_a     <= {WIDTH{1'b0}};
      r_ma    <= {WIDTH{1'b0}};
      r_mb    <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_cnt   <= 6'd0;
      r_op    <= funct3;
      r_rd    <= rd_in;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_divz  <= w_is_div && (rs2_val == {WIDTH{1'b0}});
      r_a     <= rs1_val;
      r_ma    <= w_ma;
      r_mb    <= w_mb;
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= w_is_div ? w_ma : w_mb;
    end else if (r_state == S_CALC) begin
      r_cnt <= (r_cnt == LAST_ITER) ? 6'd0 : r_cnt + 6'd1;
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Registered outputs; result and rd_out only change when DONE completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_rd_out <= 5'd0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE) || (r_state == S_DONE);
      r_done  <= (r_state == S_DONE);
      r_rd_en <= (r_state == S_DONE) && (r_rd != 5'd0);
      if (r_state == S_DONE) begin
        r_result <= w_final;
        r_rd_out <= r_rd;
      end else begin
        r_result <= r_result;
        r_rd_out <= r_rd_out;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign rd_en  = r_rd_en;
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, data width; only 32 is supported, and the iteration count equals WIDTH.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset_n  in  1  asynchronous active-low reset.
REQ-005 Port: start  in  1  launch request; sampled only in IDLE.
REQ-006 Port: funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: rs1_val  in  32  operand A (register-file x1 output).
REQ-008 Port: rs2_val  in  32  operand B (register-file x2 output).
REQ-009 Port: rd_in  in  5  destination register index.
REQ-010 Port: busy  out  1  high while an operation is in flight, including the DONE cycle.
REQ-011 Port: done  out  1  one-cycle pulse when result is valid.
REQ-012 Port: result  out  32  writeback data (feeds register-file xd).
REQ-013 Port: rd_out  out  5  captured destination index (feeds register-file rd).
REQ-014 Port: rd_en  out  1  writeback enable (feeds register-file rd_en).

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 IDLE -> CALC on a clock edge with start=1; rs1_val, rs2_val, funct3 and rd_in are captured on that edge.
REQ-017 CALC SHALL perform exactly WIDTH iterations, one per cycle, counted by a 6-bit counter from 0 to WIDTH-1, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-019 Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH+1, i.e. 33 cycles for WIDTH=32. Latency is identical for all ops and special cases.
REQ-020 start while busy=1 SHALL be ignored, with no queuing. start in the DONE cycle is also ignored.
REQ-021 Multiply: unsigned shift-add on operand magnitudes, producing a 64-bit product.
  - MUL returns product[31:0].
  - MULH treats both operands as signed and returns [63:32].
  - MULHSU treats A as signed and B as unsigned, and returns [63:32].
  - MULHU treats both as unsigned and returns [63:32].
  - The product is negated when exactly one signed operand is negative.
REQ-022 Divide: restoring division, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(A) xor sign(B), for signed ops.
  - Remainder sign = sign(A).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
REQ-023 Divide by zero SHALL return:
  - quotient 0xFFFFFFFF for both DIV and DIVU;
  - remainder equal to A.
REQ-024 Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM) SHALL return quotient 0x80000000 and remainder 0.
REQ-025 rd_en SHALL equal done AND (rd_out != 0); result is still driven when rd_out=0.
REQ-026 result and rd_out SHALL hold their values from DONE until the next DONE; rd_en and done are 0 outside DONE.
REQ-027 Operand changes on rs1_val/rs2_val after capture SHALL NOT affect the result.

Reset
REQ-028 reset_n=0 SHALL immediately force:
  - state to IDLE;
  - busy, done and rd_en to 0;
  - result to 0 and rd_out to 0;
  - the iteration counter and datapath registers to 0.
REQ-029 Reset mid-CALC SHALL abort the operation with no done pulse. The first start after reset_n deasserts SHALL be accepted normally.

Verification
REQ-030 MUL: A=7, B=0xFFFFFFFD, rd=5 -> exactly 33 cycles later: done=1, result=0xFFFFFFEB, rd_out=5, rd_en=1 for one cycle. busy=1 throughout.
REQ-031 High multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 Signed divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF;
  - REM 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
  - REM of the same operands -> 0.
  All complete in 33 cycles.
REQ-034 Write suppression and busy handling: MUL with rd_in=0 -> done=1, rd_en=0. A second start pulsed at cycle 10 of CALC is ignored: only one done, with the first operation's result.
REQ-035 Reset mid-operation: reset_n low at cycle 12 of CALC -> busy=0 and result=0 immediately, no done. A new DIVU 9/3 after release -> 3 at cycle 33.
